// File: rtl/alu_seq.sv
// Command sequencer for the 2-bit ALU: buffers commands in a FIFO, issues them one at a time,
// and returns each captured 4-bit result with its tag in command order.
module alu_seq #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_a,
  input  logic [1:0]               cmd_b,
  input  logic [1:0]               cmd_op,
  input  logic [1:0]               cmd_tag,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [3:0]               res_r,
  output logic [1:0]               res_tag,
  output logic [1:0]               alu_a,
  output logic [1:0]               alu_b,
  output logic [1:0]               alu_op,
  output logic                     alu_rst,
  input  logic [3:0]               alu_r,
  output logic                     busy,
  output logic [7:0]               done_cnt,
  output logic [1:0]               dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0] tag;
    logic [1:0] op;
    logic [1:0] b;
    logic [1:0] a;
  } cmd_t;

  state_e      state_q, state_d;
  cmd_t        mem_q [DEPTH];
  cmd_t        head;
  logic [AW:0] wr_ptr_q, rd_ptr_q, count;
  logic        empty, full, push, pop, ack, capture;

  logic [1:0]  alu_a_q, alu_b_q, alu_op_q, tag_pend_q, res_tag_q;
  logic        alu_rst_q, res_valid_q;
  logic [3:0]  res_r_q;
  logic [7:0]  done_cnt_q;

  // Both ports transfer on a rising edge where valid && ready; a producer holds its payload
  // stable while valid is high and ready is low, and valid never drops before the transfer.
  assign count     = wr_ptr_q - rd_ptr_q;
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign cmd_ready = rst && !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (!empty) state_d = S_ISSUE;
      S_ISSUE:    state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (res_valid_q && res_ready) state_d = empty ? S_IDLE : S_ISSUE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack     = (state_q == S_WAIT_ACK) && res_valid_q && res_ready;
    capture = (state_q == S_ISSUE);
    pop     = !empty && ((state_q == S_IDLE) || ack);
  end

  // Storage carries no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{tag: cmd_tag, op: cmd_op, b: cmd_b, a: cmd_a};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_rst_q   <= 1'b1;
      tag_pend_q  <= '0;
      res_r_q     <= '0;
      res_tag_q   <= '0;
      res_valid_q <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      if (ack) begin
        res_valid_q <= 1'b0;
        done_cnt_q  <= done_cnt_q + 8'd1;
      end
      if (pop) begin
        alu_a_q    <= head.a;
        alu_b_q    <= head.b;
        alu_op_q   <= head.op;
        tag_pend_q <= head.tag;
        alu_rst_q  <= 1'b0;
      end
      if (capture) begin
        res_r_q     <= alu_r;
        res_tag_q   <= tag_pend_q;
        res_valid_q <= 1'b1;
        alu_rst_q   <= 1'b1;
      end
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_rst   = alu_rst_q;
  assign res_valid = res_valid_q;
  assign res_r     = res_r_q;
  assign res_tag   = res_tag_q;
  assign done_cnt  = done_cnt_q;
  assign busy      = !empty || (state_q != S_IDLE);
  assign dbg_state = state_q;
  assign dbg_count = count;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural ALU and an in-order result scoreboard.
module tb_alu_seq;
  localparam int DEPTH = 4;
  localparam int BOUND = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_a = '0, cmd_b = '0, cmd_op = '0, cmd_tag = '0;
  logic       res_valid, res_ready = 1'b0;
  logic [3:0] res_r;
  logic [1:0] res_tag, alu_a, alu_b, alu_op;
  logic       alu_rst;
  logic [3:0] alu_r;
  logic       busy;
  logic [7:0] done_cnt;
  logic [1:0] dbg_state;
  logic [2:0] dbg_count;

  int         checks = 0;
  int         failures = 0;
  logic [5:0] exp_q[$];
  logic [7:0] exp_done = '0;

  alu_seq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_r(res_r), .res_tag(res_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_rst(alu_rst), .alu_r(alu_r),
    .busy(busy), .done_cnt(done_cnt), .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // Clock and reference ALU (parked output reads zero)
  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return {2'b00, a} + {2'b00, b};
      2'd1:    return {2'b00, a} - {2'b00, b};
      2'd2:    return {2'b00, a & b};
      default: return {2'b00, a | b};
    endcase
  endfunction

  always_comb alu_r = alu_rst ? 4'h0 : alu_f(alu_a, alu_b, alu_op);

  task automatic check(input string name, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Driver tasks; each is entered just after a falling edge and returns just after one.
  task automatic send(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op, input logic [1:0] tag);
    int n = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
    while (!cmd_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) check("cmd_accept_timeout", 8'd0, 8'd1);
    exp_q.push_back({tag, alu_f(a, b, op)});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {7'd0, n < BOUND}, 8'd1);
    check("done_cnt_model", done_cnt, exp_done);
  endtask

  task automatic tick(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  // Scoreboard: a transfer happens at the next rising edge when valid && ready here.
  always @(negedge clk) begin
    logic [5:0] e;
    #2;
    if (!rst) exp_done = '0;
    else if (res_valid && res_ready) begin
      if (exp_q.size() == 0) check("spurious_result", {7'd0, res_valid}, 8'd0);
      else begin
        e = exp_q.pop_front();
        check("res_r", {4'd0, res_r}, {4'd0, e[3:0]});
        check("res_tag", {6'd0, res_tag}, {6'd0, e[5:4]});
        exp_done = exp_done + 8'd1;
      end
    end
  end

  initial begin
    // Reset state
    tick(2);
    check("rst_res_valid", {7'd0, res_valid}, 8'd0);
    check("rst_res_r", {4'd0, res_r}, 8'd0);
    check("rst_res_tag", {6'd0, res_tag}, 8'd0);
    check("rst_alu_abo", {2'd0, alu_a, alu_b, alu_op}, 8'd0);
    check("rst_alu_rst", {7'd0, alu_rst}, 8'd1);
    check("rst_done_cnt", done_cnt, 8'd0);
    check("rst_cmd_ready", {7'd0, cmd_ready}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_state", {6'd0, dbg_state}, 8'd0);
    rst = 1'b1;
    res_ready = 1'b1;
    #1 check("cmd_ready_after_rst", {7'd0, cmd_ready}, 8'd1);
    @(negedge clk);

    // Single add: 2+3 tag 1
    send(2'd2, 2'd3, 2'd0, 2'd1);
    @(negedge clk);
    check("add_alu_rst", {7'd0, alu_rst}, 8'd0);
    check("add_alu_a", {6'd0, alu_a}, 8'd2);
    check("add_alu_b", {6'd0, alu_b}, 8'd3);
    check("add_alu_op", {6'd0, alu_op}, 8'd0);
    check("add_state_issue", {6'd0, dbg_state}, 8'd1);
    check("add_valid_low", {7'd0, res_valid}, 8'd0);
    @(negedge clk);
    check("add_valid", {7'd0, res_valid}, 8'd1);
    check("add_res_r", {4'd0, res_r}, 8'h05);
    check("add_res_tag", {6'd0, res_tag}, 8'd1);
    @(negedge clk);
    check("add_valid_drop", {7'd0, res_valid}, 8'd0);
    check("add_alu_park", {7'd0, alu_rst}, 8'd1);
    check("add_done_cnt", done_cnt, 8'd1);
    check("add_busy", {7'd0, busy}, 8'd0);

    // Opcode sweep back to back: results every 2 cycles
    send(2'd1, 2'd2, 2'd1, 2'd2);
    send(2'd3, 2'd1, 2'd2, 2'd3);
    send(2'd2, 2'd1, 2'd3, 2'd0);
    check("sweep_v0", {7'd0, res_valid}, 8'd1);
    check("sweep_r0", {4'd0, res_r}, 8'h0F);
    @(negedge clk); check("sweep_v1", {7'd0, res_valid}, 8'd0);
    @(negedge clk); check("sweep_v2", {7'd0, res_valid}, 8'd1);
    check("sweep_r2", {4'd0, res_r}, 8'h01);
    @(negedge clk); check("sweep_v3", {7'd0, res_valid}, 8'd0);
    @(negedge clk); check("sweep_v4", {7'd0, res_valid}, 8'd1);
    check("sweep_r4", {4'd0, res_r}, 8'h03);
    check("sweep_tag4", {6'd0, res_tag}, 8'd0);
    drain();

    // Backpressure until full, then release
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), 2'(i), 2'(i));
    check("full_count", {5'd0, dbg_count}, 8'd4);
    check("full_cmd_ready", {7'd0, cmd_ready}, 8'd0);
    check("full_state", {6'd0, dbg_state}, 8'd2);
    check("full_valid", {7'd0, res_valid}, 8'd1);
    cmd_a = 2'd3; cmd_b = 2'd3; cmd_op = 2'd0; cmd_tag = 2'd1; cmd_valid = 1'b1;
    tick(3);
    check("full_still_blocked", {7'd0, cmd_ready}, 8'd0);
    check("full_count_hold", {5'd0, dbg_count}, 8'd4);
    res_ready = 1'b1;
    @(negedge clk);
    check("no_full_bypass", {5'd0, dbg_count}, 8'd3);
    check("ready_after_pop", {7'd0, cmd_ready}, 8'd1);
    exp_q.push_back({2'd1, alu_f(2'd3, 2'd3, 2'd0)});
    @(negedge clk);
    cmd_valid = 1'b0;
    drain();

    // Simultaneous push and pop at count 2
    res_ready = 1'b0;
    send(2'd1, 2'd1, 2'd0, 2'd0);
    send(2'd2, 2'd1, 2'd1, 2'd1);
    send(2'd3, 2'd2, 2'd2, 2'd2);
    check("pp_count_before", {5'd0, dbg_count}, 8'd2);
    check("pp_valid", {7'd0, res_valid}, 8'd1);
    cmd_a = 2'd1; cmd_b = 2'd2; cmd_op = 2'd3; cmd_tag = 2'd3; cmd_valid = 1'b1;
    res_ready = 1'b1;
    exp_q.push_back({2'd3, alu_f(2'd1, 2'd2, 2'd3)});
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pp_count_after", {5'd0, dbg_count}, 8'd2);
    drain();

    // Reset in WAIT_ACK with 3 commands queued
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2'd1, 2'(i), 2'd0, 2'(i));
    check("mid_count", {5'd0, dbg_count}, 8'd3);
    check("mid_state", {6'd0, dbg_state}, 8'd2);
    check("mid_done_nonzero", {7'd0, done_cnt != 8'd0}, 8'd1);
    #1 rst = 1'b0;
    #1;
    check("mid_res_valid", {7'd0, res_valid}, 8'd0);
    check("mid_alu_rst", {7'd0, alu_rst}, 8'd1);
    check("mid_done_cnt", done_cnt, 8'd0);
    check("mid_cmd_ready", {7'd0, cmd_ready}, 8'd0);
    check("mid_busy", {7'd0, busy}, 8'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    res_ready = 1'b1;
    tick(5);
    check("post_rst_busy", {7'd0, busy}, 8'd0);
    check("post_rst_valid", {7'd0, res_valid}, 8'd0);
    check("post_rst_count", {5'd0, dbg_count}, 8'd0);

    // 256 completions: counter wraps, pointers wrap many times
    send(2'd0, 2'd1, 2'd1, 2'd2);
    for (int i = 0; i < 255; i++)
      send(2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
           2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)));
    drain();
    check("wrap_done_cnt", done_cnt, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
